// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory/IO port: sticky priority with a
// bounded burst length, combinational grant, and 1-cycle tagged read return.
module dmem_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [2:0]    m0_rwsel,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [2:0]    m1_rwsel,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_wren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_rwsel,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    logic          owner_q, owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_tag_q, rd_tag_d;

    logic any_gnt_s;
    logic gnt_sel_s;
    logic gnt_we_s;
    logic other_req_s;

    // Grant selection: under contention the owner keeps the port until its burst is spent
    always_comb begin
        any_gnt_s = m0_req | m1_req;
        case ({m1_req, m0_req})
            2'b01:   gnt_sel_s = 1'b0;
            2'b10:   gnt_sel_s = 1'b1;
            2'b11:   gnt_sel_s = (burst_cnt_q < MAX_CNT) ? owner_q : ~owner_q;
            default: gnt_sel_s = owner_q;
        endcase
        gnt_we_s    = gnt_sel_s ? m1_we : m0_we;
        other_req_s = gnt_sel_s ? m0_req : m1_req;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q     <= 1'b0;
            burst_cnt_q <= {CW{1'b0}};
            rd_pend_q   <= 1'b0;
            rd_tag_q    <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_tag_q    <= rd_tag_d;
        end
    end

    // Next-state: ownership, burst counting and read tagging
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = {CW{1'b0}};
        rd_pend_d   = any_gnt_s & ~gnt_we_s;
        rd_tag_d    = rd_tag_q;
        if (any_gnt_s) begin
            if (!gnt_we_s) begin
                rd_tag_d = gnt_sel_s;
            end else begin
                rd_tag_d = rd_tag_q;
            end
            if (gnt_sel_s != owner_q) begin
                owner_d     = gnt_sel_s;
                burst_cnt_d = other_req_s ? 4'd1 : 4'd0;
            end else if (other_req_s) begin
                burst_cnt_d = (burst_cnt_q >= MAX_CNT) ? MAX_CNT : burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = {CW{1'b0}};
            end
        end else begin
            burst_cnt_d = {CW{1'b0}};
        end
    end

    // Outputs: memory-port mux and tagged read return, all forced low while in reset
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_rwsel = 3'b000;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = {DW{1'b0}};
        m1_rdata  = {DW{1'b0}};
        if (rst) begin
            m0_gnt   = any_gnt_s & ~gnt_sel_s;
            m1_gnt   = any_gnt_s & gnt_sel_s;
            mem_en   = any_gnt_s;
            mem_wren = any_gnt_s & gnt_we_s;
            if (any_gnt_s) begin
                mem_addr  = gnt_sel_s ? m1_addr  : m0_addr;
                mem_wdata = gnt_sel_s ? m1_wdata : m0_wdata;
                mem_rwsel = gnt_sel_s ? m1_rwsel : m0_rwsel;
            end else begin
                mem_addr  = {AW{1'b0}};
                mem_wdata = {DW{1'b0}};
                mem_rwsel = 3'b000;
            end
            m0_rvalid = rd_pend_q & ~rd_tag_q;
            m1_rvalid = rd_pend_q & rd_tag_q;
            m0_rdata  = (rd_pend_q & ~rd_tag_q) ? mem_rdata : {DW{1'b0}};
            m1_rdata  = (rd_pend_q & rd_tag_q)  ? mem_rdata : {DW{1'b0}};
        end else begin
            m0_gnt = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [2:0]    m0_rwsel, m1_rwsel;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en, mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_rwsel;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int mdl_owner  = 0;
    int mdl_streak = 0;
    int mdl_last_g = -1;
    int pend_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rwsel(m0_rwsel), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rwsel(m1_rwsel), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rwsel(mem_rwsel), .mem_rdata(mem_rdata)
    );

    function automatic int pick();
        if (rst !== 1'b1) return -1;
        if (m0_req && m1_req) return (mdl_streak < MB) ? mdl_owner : 1 - mdl_owner;
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    function automatic logic exp_rv(int k);
        return (rst === 1'b1) && (pend_q.size() > 0) && (pend_q[0] == k);
    endfunction

    task automatic model_edge();
        int   g;
        logic other;
        g = pick();
        mdl_last_g = g;
        if (rst !== 1'b1) begin
            mdl_owner  = 0;
            mdl_streak = 0;
            pend_q.delete();
        end else begin
            pend_q.delete();
            if (g >= 0 && ((g == 0) ? m0_we : m1_we) == 1'b0) pend_q.push_back(g);
            other = (g == 0) ? m1_req : m0_req;
            if (g < 0) mdl_streak = 0;
            else if (g != mdl_owner) begin
                mdl_owner  = g;
                mdl_streak = other ? 1 : 0;
            end else if (other) mdl_streak = (mdl_streak + 1 > MB) ? MB : mdl_streak + 1;
            else mdl_streak = 0;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_rwsel = 3'b000;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_rwsel = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 12'h123; m1_wdata = 32'h1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_wren, mem_addr, mem_wdata,
                 mem_rwsel, m0_rdata, m1_rdata} !== '0)
                begin bad++; $display("FAIL reset_outputs: en=%b gnt=%b%b addr=%h want all zero",
                                      mem_en, m0_gnt, m1_gnt, mem_addr); end
            adv();
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10)
            begin bad++; $display("FAIL reset_release_gnt: got %b%b want 10", m0_gnt, m1_gnt); end
        adv();
        idle();
        adv();
        adv();
    endtask

    task automatic test_single_read();
        idle();
        m0_req = 1'b1; m0_addr = 12'h010;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, mem_en, mem_wren, mem_addr} !== {4'b1010, 12'h010})
            begin bad++; $display("FAIL single_read_grant: got %b%b%b%b %h want 1010 010",
                                  m0_gnt, m1_gnt, mem_en, mem_wren, mem_addr); end
        adv();
        idle();
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {2'b10, 32'hDEADBEEF, 32'h0})
            begin bad++; $display("FAIL single_read_data: got rv=%b%b rd0=%h rd1=%h want 10 deadbeef 0",
                                  m0_rvalid, m1_rvalid, m0_rdata, m1_rdata); end
        adv();
    endtask

    task automatic test_back_to_back();
        logic exp1, prev;
        idle();
        m0_req = 1'b1; m1_req = 1'b1;
        prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp1 = ((i / 4) % 2) == 1;
            mem_rdata = DW'($urandom());
            @(negedge clk);
            total++;
            if ({m0_gnt, m1_gnt} !== {~exp1, exp1})
                begin bad++; $display("FAIL burst_gnt[%0d]: got %b%b want %b%b", i, m0_gnt, m1_gnt, ~exp1, exp1); end
            if (i > 0) begin
                total++;
                if ({m0_rvalid, m1_rvalid, (prev ? m1_rdata : m0_rdata)} !== {~prev, prev, mem_rdata})
                    begin bad++; $display("FAIL burst_rvalid[%0d]: got %b%b want %b%b", i,
                                          m0_rvalid, m1_rvalid, ~prev, prev); end
            end
            prev = exp1;
            adv();
        end
        idle();
        adv();
    endtask

    task automatic test_m1_write();
        idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h7F0; m1_wdata = 32'h12345678; m1_rwsel = 3'b010;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, mem_en, mem_wren, mem_addr, mem_wdata, mem_rwsel} !==
            {4'b0111, 12'h7F0, 32'h12345678, 3'b010})
            begin bad++; $display("FAIL m1_write: got en=%b we=%b a=%h d=%h s=%b want 1 1 7f0 12345678 010",
                                  mem_en, mem_wren, mem_addr, mem_wdata, mem_rwsel); end
        adv();
        idle();
        @(negedge clk);
        total++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00)
            begin bad++; $display("FAIL m1_write_no_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); end
        adv();
    endtask

    task automatic test_alternate();
        idle();
        m0_req = 1'b1; m0_addr = 12'h020;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10)
            begin bad++; $display("FAIL alt_gnt0: got %b%b want 10", m0_gnt, m1_gnt); end
        adv();
        idle();
        m1_req = 1'b1; m1_addr = 12'h030;
        mem_rdata = 32'hA5A50001;
        @(negedge clk);
        total++;
        if ({m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {3'b110, 32'hA5A50001, 32'h0})
            begin bad++; $display("FAIL alt_rv0: got g1=%b rv=%b%b rd0=%h rd1=%h want 1 10 a5a50001 0",
                                  m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata); end
        adv();
        idle();
        mem_rdata = 32'h5A5A0002;
        @(negedge clk);
        total++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {2'b01, 32'h0, 32'h5A5A0002})
            begin bad++; $display("FAIL alt_rv1: got rv=%b%b rd0=%h rd1=%h want 01 0 5a5a0002",
                                  m0_rvalid, m1_rvalid, m0_rdata, m1_rdata); end
        adv();
    endtask

    task automatic test_reset_mid_read();
        for (int k = 0; k < 2; k++) begin
            idle();
            if (k == 0) m0_req = 1'b1; else m1_req = 1'b1;
            m0_addr = 12'h040; m1_addr = 12'h044;
            @(negedge clk);
            total++;
            if ({m0_gnt, m1_gnt} !== ((k == 0) ? 2'b10 : 2'b01))
                begin bad++; $display("FAIL midrst_gnt[%0d]: got %b%b", k, m0_gnt, m1_gnt); end
            adv();
            rst = 1'b0;
            idle();
            mem_rdata = 32'hCAFEF00D;
            @(negedge clk);
            total++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0)
                begin bad++; $display("FAIL midrst_rvalid_in_reset[%0d]: got %b%b want 00", k, m0_rvalid, m1_rvalid); end
            adv();
            rst = 1'b1;
            m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                if (j == 0) begin
                    total++;
                    if ({m0_rvalid, m1_rvalid} !== 2'b00)
                        begin bad++; $display("FAIL midrst_rvalid_after[%0d]: got %b%b want 00", k, m0_rvalid, m1_rvalid); end
                end
                total++;
                if ({m0_gnt, m1_gnt} !== ((j == 4) ? 2'b01 : 2'b10))
                    begin bad++; $display("FAIL midrst_state[%0d.%0d]: got %b%b", k, j, m0_gnt, m1_gnt); end
                adv();
            end
            idle();
            adv();
        end
    endtask

    task automatic test_random();
        logic [115:0] act, exp;
        int           g;
        logic         wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [2:0]    es;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            if (!(m0_req && mdl_last_g != 0)) begin
                m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom());
                m0_addr = AW'($urandom()); m0_wdata = DW'($urandom()); m0_rwsel = 3'($urandom());
            end
            if (!(m1_req && mdl_last_g != 1)) begin
                m1_req = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom());
                m1_addr = AW'($urandom()); m1_wdata = DW'($urandom()); m1_rwsel = 3'($urandom());
            end
            mem_rdata = DW'($urandom());
            @(negedge clk);
            g  = pick();
            wr = (g == 0) ? m0_we : (g == 1) ? m1_we : 1'b0;
            ea = (g == 0) ? m0_addr : (g == 1) ? m1_addr : '0;
            ed = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
            es = (g == 0) ? m0_rwsel : (g == 1) ? m1_rwsel : 3'b000;
            exp = {(g == 0), (g == 1), (g >= 0), wr, ea, ed, es, exp_rv(0), exp_rv(1),
                   (exp_rv(0) ? mem_rdata : 32'h0), (exp_rv(1) ? mem_rdata : 32'h0)};
            act = {m0_gnt, m1_gnt, mem_en, mem_wren, mem_addr, mem_wdata, mem_rwsel,
                   m0_rvalid, m1_rvalid, m0_rdata, m1_rdata};
            total++;
            if (act !== exp)
                begin bad++; $display("FAIL random[%0d]: got %h want %h", i, act, exp); end
            adv();
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        mem_rdata = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_m1_write();
        test_alternate();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
